// File: rtl/cam_pkg.sv
// Shared state type, default sizing and the popcount helper for the CAM
// match-vector encoder.
package cam_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int CAM_DEPTH_DEF  = 32;

    // Widest match vector the popcount helper handles; narrower vectors are zero-extended.
    localparam int POPCOUNT_MAX   = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    function automatic int unsigned popcount(input logic [POPCOUNT_MAX-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POPCOUNT_MAX; i++) begin
            n = n + {31'b0, vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder: reports the position of the lowest set bit
// of vec_i and whether any bit is set at all.
module cam_prio_enc
    import cam_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CAM_DEPTH  = CAM_DEPTH_DEF
) (
    input  logic [CAM_DEPTH-1:0]  vec_i,
    output logic [ADDR_WIDTH-1:0] idx_o,
    output logic                  found_o
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = ADDR_WIDTH'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_match_encoder.sv
// Captures one CAM match vector per handshake and streams the binary index of
// every hit, lowest first, reporting the hit count and flagging misses.
module cam_match_encoder
    import cam_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CAM_DEPTH  = CAM_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  match_valid_i,
    output logic                  match_ready_o,
    input  logic [CAM_DEPTH-1:0]  match_vec_i,
    output logic                  addr_valid_o,
    input  logic                  addr_ready_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  addr_last_o,
    output logic [ADDR_WIDTH:0]   hit_count_o,
    output logic                  miss_o
);

    state_e                  state_q;
    logic [CAM_DEPTH-1:0]    pending_q;
    logic [ADDR_WIDTH:0]     hitCount_q;
    logic                    miss_q;

    logic [ADDR_WIDTH-1:0]   lowIdx;
    logic                    lowFound;
    logic [CAM_DEPTH-1:0]    pending_d;
    logic                    singleHit;
    logic [ADDR_WIDTH:0]     vecCount;
    logic                    vecAccept;
    logic                    beatAccept;

    cam_prio_enc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CAM_DEPTH  (CAM_DEPTH)
    ) u_prio_enc (
        .vec_i   (pending_q),
        .idx_o   (lowIdx),
        .found_o (lowFound)
    );

    // Clearing the lowest set bit is exactly the pending state after one accepted beat.
    assign pending_d  = pending_q & (pending_q - CAM_DEPTH'(1));
    assign singleHit  = (pending_d == '0);
    assign vecCount   = (ADDR_WIDTH + 1)'(popcount(POPCOUNT_MAX'(match_vec_i)));

    assign match_ready_o = (state_q == IDLE);
    assign addr_valid_o  = (state_q == SCAN) && lowFound;
    assign addr_o        = lowIdx;
    assign addr_last_o   = addr_valid_o && singleHit;
    assign hit_count_o   = hitCount_q;
    assign miss_o        = miss_q;

    assign vecAccept  = match_valid_i && match_ready_o;
    assign beatAccept = addr_valid_o && addr_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            hitCount_q <= '0;
            miss_q     <= 1'b0;
        end else begin
            miss_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (vecAccept) begin
                        pending_q  <= match_vec_i;
                        hitCount_q <= vecCount;
                        miss_q     <= (match_vec_i == '0);
                        if (match_vec_i != '0) begin
                            state_q <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (beatAccept) begin
                        pending_q <= pending_d;
                        if (addr_last_o) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_match_encoder.sv
// Self-checking bench for cam_match_encoder: directed scenarios followed by
// random traffic, compared against a queue-based model of pending hits.
module tb_cam_match_encoder;

    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          match_valid_i = 1'b0;
    logic          match_ready_o;
    logic [31:0]   match_vec_i = '0;
    logic          addr_valid_o;
    logic          addr_ready_i = 1'b0;
    logic [AW-1:0] addr_o;
    logic          addr_last_o;
    logic [AW:0]   hit_count_o;
    logic          miss_o;

    int checks   = 0;
    int failures = 0;

    // Model: hit indices still to be emitted, plus the reported count and miss flag.
    int expQ[$];
    int expCount = 0;
    bit expMiss  = 1'b0;

    always #5 clk = ~clk;

    cam_match_encoder #(
        .ADDR_WIDTH (AW),
        .CAM_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .match_valid_i (match_valid_i),
        .match_ready_o (match_ready_o),
        .match_vec_i   (match_vec_i),
        .addr_valid_o  (addr_valid_o),
        .addr_ready_i  (addr_ready_i),
        .addr_o        (addr_o),
        .addr_last_o   (addr_last_o),
        .hit_count_o   (hit_count_o),
        .miss_o        (miss_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] vec, input logic ready);
        match_valid_i = valid;
        match_vec_i   = vec;
        addr_ready_i  = ready;
    endtask

    task automatic modelReset();
        expQ.delete();
        expCount = 0;
        expMiss  = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT saw at that edge.
    task automatic modelStep();
        if (expQ.size() == 0) begin
            expMiss = match_valid_i && (match_vec_i == 32'h0);
            if (match_valid_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (match_vec_i[i]) expQ.push_back(i);
                end
                expCount = expQ.size();
            end
        end else begin
            expMiss = 1'b0;
            if (addr_ready_i) void'(expQ.pop_front());
        end
    endtask

    task automatic checkOutput();
        check("ready", {31'b0, match_ready_o}, {31'b0, expQ.size() == 0});
        check("valid", {31'b0, addr_valid_o}, {31'b0, expQ.size() != 0});
        if (expQ.size() != 0) begin
            check("addr", {27'b0, addr_o}, expQ[0]);
            check("last", {31'b0, addr_last_o}, {31'b0, expQ.size() == 1});
        end
        check("count", {26'b0, hit_count_o}, expCount);
        check("miss", {31'b0, miss_o}, {31'b0, expMiss});
    endtask

    task automatic cycle();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_ready"}, {31'b0, match_ready_o}, 32'd1);
        check({tag, "_valid"}, {31'b0, addr_valid_o}, 32'd0);
        check({tag, "_addr"},  {27'b0, addr_o}, 32'd0);
        check({tag, "_last"},  {31'b0, addr_last_o}, 32'd0);
        check({tag, "_count"}, {26'b0, hit_count_o}, 32'd0);
        check({tag, "_miss"},  {31'b0, miss_o}, 32'd0);
    endtask

    initial begin
        int n;
        int mode;
        logic [31:0] rvec;

        // Reset asserted between edges must take effect immediately.
        applyStimulus(1'b0, 32'h0, 1'b0);
        #3 rst_n = 1'b0;
        #1 checkResetValues("rst");
        modelReset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("rst_rel_ready", {31'b0, match_ready_o}, 32'd1);

        // Single hit at entry 8.
        applyStimulus(1'b1, 32'h0000_0100, 1'b1);
        cycle();
        check("single_addr", {27'b0, addr_o}, 32'd8);
        check("single_last", {31'b0, addr_last_o}, 32'd1);
        check("single_count", {26'b0, hit_count_o}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        cycle();
        check("single_idle", {31'b0, match_ready_o}, 32'd1);

        // Multi-hit with backpressure on address 4; a new vector offered meanwhile is ignored.
        applyStimulus(1'b1, 32'h8000_0011, 1'b1);
        cycle();
        check("multi_first", {27'b0, addr_o}, 32'd0);
        applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b1);
        cycle();
        applyStimulus(1'b1, 32'hFFFF_0000, 1'b0);
        repeat (3) begin
            cycle();
            check("bp_hold", {27'b0, addr_o}, 32'd4);
            check("bp_last", {31'b0, addr_last_o}, 32'd0);
        end
        applyStimulus(1'b1, 32'hFFFF_0000, 1'b1);
        cycle();
        check("multi_addr31", {27'b0, addr_o}, 32'd31);
        check("multi_last", {31'b0, addr_last_o}, 32'd1);
        check("multi_count", {26'b0, hit_count_o}, 32'd3);
        applyStimulus(1'b0, 32'h0, 1'b1);
        cycle();

        // Miss followed immediately by a new vector.
        applyStimulus(1'b1, 32'h0, 1'b1);
        cycle();
        check("miss_pulse", {31'b0, miss_o}, 32'd1);
        check("miss_ready", {31'b0, match_ready_o}, 32'd1);
        applyStimulus(1'b1, 32'h0000_0100, 1'b1);
        cycle();
        check("miss_drop", {31'b0, miss_o}, 32'd0);
        check("b2b_addr", {27'b0, addr_o}, 32'd8);
        applyStimulus(1'b0, 32'h0, 1'b1);
        cycle();

        // Full vector: 32 beats, 33 cycles from acceptance back to ready.
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1);
        cycle();
        check("full_count", {26'b0, hit_count_o}, 32'd32);
        applyStimulus(1'b0, 32'h0, 1'b1);
        n = 1;
        while (!match_ready_o && n < 100) begin
            cycle();
            n++;
        end
        check("full_cycles", n, 32'd33);

        // Top entry only.
        applyStimulus(1'b1, 32'h8000_0000, 1'b1);
        cycle();
        check("top_addr", {27'b0, addr_o}, 32'd31);
        check("top_last", {31'b0, addr_last_o}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        cycle();

        // Reset mid-scan after the first beat discards the remaining hits.
        applyStimulus(1'b1, 32'h0000_00F0, 1'b1);
        cycle();
        check("rms_first", {27'b0, addr_o}, 32'd4);
        applyStimulus(1'b0, 32'h0, 1'b1);
        cycle();
        #2 rst_n = 1'b0;
        #1 checkResetValues("rms");
        modelReset();
        repeat (2) @(posedge clk);
        #1 check("rms_hold_valid", {31'b0, addr_valid_o}, 32'd0);
        rst_n = 1'b1;
        repeat (3) cycle();
        applyStimulus(1'b1, 32'h0000_0002, 1'b1);
        cycle();
        check("rms_new_addr", {27'b0, addr_o}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        cycle();

        // Random traffic against the model.
        repeat (400) begin
            mode = $urandom_range(0, 7);
            case (mode)
                0:       rvec = 32'h0;
                1:       rvec = 32'hFFFF_FFFF;
                2:       rvec = 32'h8000_0000;
                default: rvec = $urandom & $urandom & $urandom;
            endcase
            applyStimulus(1'($urandom_range(0, 1)), rvec, ($urandom_range(0, 3) != 0));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
